// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: display scan-out > clear/fill engine > host.
// Grants are combinational; read returns come back one cycle after the grant.
module fb_arbiter #(
    parameter int FB_DEPTH = 4800,
    parameter int AW       = 13,
    parameter int DW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_rdata,
    output logic          disp_rvalid,
    input  logic          host_req,
    input  logic          host_wen,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_value,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [AW-1:0] DEPTH = AW'(FB_DEPTH);
    localparam logic [AW-1:0] LAST  = AW'(FB_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} fill_state_t;

    fill_state_t   state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] clr_value_q;
    logic          disp_pend_q, disp_oor_q;
    logic          host_pend_q, host_oor_q;

    logic disp_in, host_in;
    logic disp_grant, fill_grant, host_grant;

    assign disp_in = disp_addr < DEPTH;
    assign host_in = host_addr < DEPTH;

    // Grants are masked by rst so every output is quiet while reset is held.
    assign disp_grant = !rst && disp_req;
    assign fill_grant = !rst && !disp_req && (state == S_FILL);
    assign host_grant = !rst && !disp_req && (state != S_FILL) && host_req;

    always_comb begin
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (disp_grant) begin
            if (disp_in) mem_addr = disp_addr;
        end else if (fill_grant) begin
            mem_wen   = 1'b1;
            mem_addr  = cnt;
            mem_wdata = clr_value_q;
        end else if (host_grant) begin
            mem_wen   = host_wen && host_in;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    assign host_ack    = host_grant;
    assign disp_rvalid = disp_pend_q;
    assign host_rvalid = host_pend_q;
    // Out-of-range reads still return, but as zero rather than whatever the RAM drives.
    assign disp_rdata  = (disp_pend_q && !disp_oor_q) ? mem_rdata : '0;
    assign host_rdata  = (host_pend_q && !host_oor_q) ? mem_rdata : '0;
    assign clr_busy    = (state == S_FILL);
    assign clr_done    = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            clr_value_q <= '0;
            disp_pend_q <= 1'b0;
            disp_oor_q  <= 1'b0;
            host_pend_q <= 1'b0;
            host_oor_q  <= 1'b0;
        end else begin
            disp_pend_q <= disp_grant;
            disp_oor_q  <= disp_grant && !disp_in;
            host_pend_q <= host_grant && !host_wen;
            host_oor_q  <= host_grant && !host_in;
            case (state)
                S_IDLE: begin
                    if (clr_start) begin
                        state       <= S_FILL;
                        cnt         <= '0;
                        clr_value_q <= clr_value;
                    end
                end
                S_FILL: begin
                    if (fill_grant) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: behavioural fb_mem, reference memory image and
// expected-data queues for the display and host read returns.
module tb_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_req;
    logic [12:0] disp_addr;
    logic [7:0]  disp_rdata;
    logic        disp_rvalid;
    logic        host_req;
    logic        host_wen;
    logic [12:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic        host_rvalid;
    logic        clr_start;
    logic [7:0]  clr_value;
    logic        clr_busy;
    logic        clr_done;
    logic        mem_wen;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    fb_arbiter #(.FB_DEPTH(4800), .AW(13), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
        .host_req(host_req), .host_wen(host_wen), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .clr_start(clr_start), .clr_value(clr_value),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- fb_mem model (registered read, old data on collision) ----------------
    logic [7:0] mem [0:4799];
    logic       mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4800; i++) mem[i] <= i[7:0];
        end else if (mem_wen && mem_addr < 13'd4800) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= (mem_addr < 13'd4800) ? mem[mem_addr] : 8'h00;
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_mem [0:4799];
    logic [7:0] host_exp_q[$];
    logic [7:0] disp_exp_q[$];
    int vectors = 0;
    int errors  = 0;
    int done_cnt = 0;
    logic disp_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) disp_prev <= disp_req && !rst;

    always @(negedge clk) begin
        if (clr_done) done_cnt++;
        if (disp_rvalid || disp_prev) chk("disp_rvalid", disp_rvalid, disp_prev);
        if (disp_rvalid) begin
            if (disp_exp_q.size() == 0) chk("disp_unexpected", 1, 0);
            else chk("disp_rdata", disp_rdata, disp_exp_q.pop_front());
        end
        if (host_rvalid) begin
            if (host_exp_q.size() == 0) chk("host_unexpected", 1, 0);
            else chk("host_rdata", host_rdata, host_exp_q.pop_front());
        end
    end

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic host_access(input logic wen, input logic [12:0] a, input logic [7:0] d,
                               output int waits);
        host_req = 1'b1; host_wen = wen; host_addr = a; host_wdata = d;
        waits = 0;
        @(negedge clk);
        while (!host_ack && waits < 20000) begin
            waits++;
            @(negedge clk);
        end
        if (host_ack) begin
            chk("host_mem_wen", mem_wen, wen && (a < 13'd4800));
            chk("host_mem_addr", mem_addr, a);
            chk("host_ack_busy", clr_busy, 0);
            if (!wen) host_exp_q.push_back((a < 13'd4800) ? exp_mem[a] : 8'h00);
            else if (a < 13'd4800) exp_mem[a] = d;
        end else begin
            chk("host_ack_timeout", 0, 1);
        end
        @(posedge clk); #1;
        host_req = 1'b0;
    endtask

    task automatic disp_read(input logic [12:0] a);
        disp_req = 1'b1; disp_addr = a;
        disp_exp_q.push_back((a < 13'd4800) ? exp_mem[a] : 8'h00);
        @(posedge clk); #1;
        disp_req = 1'b0;
    endtask

    // Pulses clr_start, optionally requests an out-of-range display read every other
    // cycle, and returns the number of cycles clr_busy stayed high.
    task automatic run_fill(input logic [7:0] v, input logic alt, output int n);
        clr_value = v; clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        n = 0;
        while (n < 20000) begin
            if (alt && n[0] == 1'b0) begin
                disp_req  = 1'b1;
                disp_addr = 13'(4800 + n % 100);
                disp_exp_q.push_back(8'h00);
            end else begin
                disp_req = 1'b0;
            end
            @(negedge clk);
            if (!clr_busy) break;
            n++;
            @(posedge clk); #1;
        end
        chk("fill_done_pulse", clr_done, 1);
        @(posedge clk); #1;
        disp_req = 1'b0;
        for (int i = 0; i < 4800; i++) exp_mem[i] = v;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w, n, bad, done_before;
        logic [12:0] a;
        logic [7:0]  d;

        for (int i = 0; i < 4800; i++) exp_mem[i] = i[7:0];
        rst = 1'b1; mem_init = 1'b1;
        host_req = 1'b1; host_wen = 1'b1; host_addr = 13'd100; host_wdata = 8'hFF;
        disp_req = 1'b1; disp_addr = 13'd5; clr_start = 1'b0; clr_value = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_host_ack", host_ack, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_disp_rvalid", disp_rvalid, 0);
        chk("rst_disp_rdata", disp_rdata, 0);
        chk("rst_host_rvalid", host_rvalid, 0);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_clr_done", clr_done, 0);
        @(posedge clk); #1;
        rst = 1'b0; mem_init = 1'b0; host_req = 1'b0; disp_req = 1'b0;

        // basic host write / read
        host_access(1'b1, 13'd100, 8'hA5, w);
        chk("host_wr_wait", w, 0);
        host_access(1'b0, 13'd100, 8'h00, w);
        chk("host_rd_wait", w, 0);

        // display and host collide for three cycles
        fork
            host_access(1'b1, 13'd200, 8'h3C, w);
            begin
                for (int i = 0; i < 3; i++) disp_read(13'(300 + i));
            end
        join
        chk("collide_wait", w, 3);
        host_access(1'b0, 13'd200, 8'h00, w);

        // random in-range traffic
        for (int i = 0; i < 16; i++) begin
            a = 13'($urandom_range(0, 4799));
            d = 8'($urandom_range(0, 255));
            host_access(1'b1, a, d, w);
            if ($urandom_range(0, 1) == 1) disp_read(a);
            else host_access(1'b0, a, 8'h00, w);
        end

        // plain fill with a host read parked during it
        fork
            run_fill(8'h55, 1'b0, n);
            begin
                repeat (10) @(posedge clk);
                #1;
                host_access(1'b0, 13'd5000, 8'h00, w);
            end
        join
        chk("fill_cycles", n, 4800);
        chk("fill_host_wait", w, 4791);
        chk("fill_done_count", done_cnt, 1);
        host_access(1'b0, 13'd0, 8'h00, w);
        host_access(1'b0, 13'd2400, 8'h00, w);
        host_access(1'b0, 13'd4799, 8'h00, w);

        // fill interleaved with display reads
        run_fill(8'h99, 1'b1, n);
        chk("fill_alt_cycles", n, 9600);
        chk("fill_alt_done_count", done_cnt, 2);
        bad = 0;
        for (int i = 0; i < 4800; i++) if (mem[i] !== 8'h99) bad++;
        chk("fill_alt_scan_bad", bad, 0);

        // out-of-range accesses
        host_access(1'b1, 13'd4800, 8'h12, w);
        chk("oor_wr_wait", w, 0);
        host_access(1'b1, 13'd8191, 8'h34, w);
        host_access(1'b0, 13'd5000, 8'h00, w);
        disp_read(13'd4800);
        disp_read(13'd4799);

        // reset during fill cycle 1000
        done_before = done_cnt;
        clr_value = 8'hC3; clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_mem_wen", mem_wen, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_busy", clr_busy, 0);
        chk("abort_done", clr_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 1000; i++) exp_mem[i] = 8'hC3;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, done_before);
        host_access(1'b0, 13'd999, 8'h00, w);
        host_access(1'b0, 13'd1000, 8'h00, w);
        disp_read(13'd0);

        repeat (3) @(posedge clk);
        chk("host_q_empty", host_exp_q.size(), 0);
        chk("disp_q_empty", disp_exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Sole owner of the single-port 80x60 byte frame buffer (fb_mem: 4800 x 8, 1-cycle registered read, read-during-write returns old data).
- Shares that port between three users:
  - the VGA scan-out reader (absolute priority);
  - a hardware clear/fill engine;
  - a host read/write port with a req/ack handshake.
- Sits between the VGA timing/pixel pipeline, the host bus and fb_mem.

Parameters:
FB_DEPTH, 4800, number of valid frame-buffer entries (80x60)
AW, 13, address width
DW, 8, data width

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
disp_req  in  1  scan-out read request this cycle
disp_addr  in  AW  scan-out read address
disp_rdata  out  DW  scan-out read data, valid when disp_rvalid
disp_rvalid  out  1  scan-out data valid (1 cycle after disp_req)
host_req  in  1  host access request; hold with addr/wen/wdata until host_ack
host_wen  in  1  1 = write, 0 = read
host_addr  in  AW  host address
host_wdata  in  DW  host write data
host_ack  out  1  host request granted this cycle
host_rdata  out  DW  host read data, valid when host_rvalid
host_rvalid  out  1  host read data valid (1 cycle after an acked read)
clr_start  in  1  pulse: start filling the whole buffer
clr_value  in  DW  fill value, sampled on an accepted clr_start
clr_busy  out  1  fill in progress
clr_done  out  1  1-cycle pulse when the fill completes
mem_wen  out  1  to fb_mem i_wen
mem_addr  out  AW  to fb_mem i_addr
mem_wdata  out  DW  to fb_mem i_wdata
mem_rdata  in  DW  from fb_mem o_rdata

Behaviour:
Arbitration:
- Combinational per cycle. Priority: display > fill engine > host.
- Display grant (disp_req=1):
  - mem_addr=disp_addr, mem_wen=0.
  - Host and fill both stall. The fill counter does not advance.
- Fill grant (state FILL, no disp_req):
  - mem_wen=1, mem_addr=cnt, mem_wdata=clr_value_q.
- Host grant (host_req=1, no disp_req, state not FILL):
  - host_ack=1.
  - mem_wen=host_wen, mem_addr=host_addr, mem_wdata=host_wdata.
- No grant: mem_wen=0, mem_addr=0, mem_wdata=0.

Read return:
- Registered owner flags disp_pend_q and host_pend_q are set for a granted display read or a granted host read.
- Next cycle, disp_rvalid or host_rvalid = the corresponding flag, and the rdata output = mem_rdata.
- Read latency is exactly 1 cycle from grant.
- rdata outputs are don't-care when their valid is low.

Out of range (addr >= FB_DEPTH):
- Display: no memory access; next cycle disp_rvalid=1, disp_rdata=0x00.
- Host: acked normally. A write is dropped (mem_wen=0). A read returns host_rvalid=1, host_rdata=0x00.

Fill FSM (IDLE, FILL, DONE):
- IDLE: clr_start=1 -> FILL, cnt<=0, clr_value_q<=clr_value.
- FILL:
  - Each fill-granted cycle writes address cnt, then cnt<=cnt+1.
  - The write at cnt==FB_DEPTH-1 moves the FSM to DONE.
  - clr_start is ignored while in FILL.
- DONE: clr_done=1 for exactly that cycle, then IDLE. clr_start is ignored in DONE.
- clr_busy = (state==FILL). The host is held off (host_ack=0) while busy.
- With no display traffic, the fill takes exactly 4800 cycles.

Reset:
- State IDLE, cnt=0, all pend flags 0.
- All outputs 0 in the cycle after reset asserts and while it is held.
- Reset mid-fill aborts the fill: no clr_done, and the buffer is left partially filled.
- Reset discards any pending read return (no rvalid).

Simultaneous events:
- disp_req and host_req in the same cycle: the display wins, host_ack=0, and the host retries the next cycle with its request held.
- clr_start and host_req in the same IDLE cycle (no disp_req): the host is acked this cycle and the fill starts next cycle.

Test Plan:
- Reset, then host write 0xA5 @ 100 and host read @ 100 -> each acked in its request cycle; read gives host_rvalid one cycle later with host_rdata=0xA5.
- disp_req and host_req (write 0x3C @ 200) together for 3 cycles, then disp_req drops -> host_ack=0 for those 3 cycles and 1 on cycle 4; disp_rvalid follows each disp_req by 1 cycle; a later read @ 200 returns 0x3C.
- clr_start with clr_value=0x55, no display traffic -> clr_busy for 4800 cycles, clr_done pulses once; reads @ 0, 2400 and 4799 return 0x55; a host_req during the fill gets no ack until after clr_done.
- Fill with disp_req every other cycle -> fill takes 9600 cycles, every address ends at the fill value, and display reads are never delayed.
- Host write @ 4800 and @ 8191 -> acked with mem_wen=0; host read @ 5000 -> host_rdata=0x00; disp_req @ 4800 -> disp_rdata=0x00.
- rst asserted at fill cycle 1000 -> clr_busy=0 the next cycle and no clr_done; address 999 reads the fill value, address 1000 keeps its old content.
